ahb_grant_scheduler: RTL and testbench

Weighted round-robin grant scheduler for the AHB arbiter. Decides which master owns the shared address/data path, and sequences handover only at legal AHB boundaries: never mid fixed-length burst, never during a locked sequence. Drives `hgrant`, `s_hmaster` and `s_hmastlock`, which control the arbiter's master-to-slave address/data muxes.

---
 rtl/ahb_grant_scheduler.sv | 106 ++++++++++
 tb/tb_ahb_grant_scheduler.sv | 106 ++++++++++
 2 files changed

// File: rtl/ahb_grant_scheduler.sv
// ahb_grant_scheduler: weighted round-robin AHB grant scheduler with burst/lock-safe handover.
// Define AHB_ARB_WEIGHT_EN to enable per-master quotas from m_weight; otherwise pure per-burst round-robin.
module ahb_grant_scheduler #(
  parameter int N_MASTERS  = 4,
  parameter int WEIGHT_W   = 4,
  parameter int DEF_MASTER = 0
) (
  input  logic                          hclk,
  input  logic                          hreset,
  input  logic [N_MASTERS-1:0]          m_busreq,
  input  logic [N_MASTERS-1:0]          m_hlock,
  input  logic [N_MASTERS*WEIGHT_W-1:0] m_weight,
  input  logic                          s_hready,
  input  logic [1:0]                    s_htrans,
  input  logic [2:0]                    s_hburst,
  output logic [N_MASTERS-1:0]          hgrant,
  output logic [$clog2(N_MASTERS)-1:0]  s_hmaster,
  output logic                          s_hmastlock
);
  localparam int IW = $clog2(N_MASTERS);
  localparam logic [1:0] PARK = 2'd0, GRANTED = 2'd1, LOCKED = 2'd2, HANDOVER = 2'd3;
  localparam logic [IW-1:0] DEF_IDX = IW'(DEF_MASTER);
  logic [1:0] r_state, w_state_nx;
  logic [IW-1:0] r_owner, w_owner_nx, w_sel, r_hmaster;
  logic [N_MASTERS-1:0] r_grant;
  logic r_mastlock;
  logic [3:0] r_beats_left, w_beats_nx, w_load;
  logic w_nonseq, w_seq, w_acc, w_bound, w_any, w_others, w_exhaust, w_release, w_clr_quota;
  assign w_nonseq = s_htrans == 2'b10;
  assign w_seq    = s_htrans == 2'b11;
  assign w_acc    = s_hready && s_htrans[1];
  assign w_load   = (s_hburst == 3'd2 || s_hburst == 3'd3) ? 4'd3 :
                    (s_hburst == 3'd4 || s_hburst == 3'd5) ? 4'd7 :
                    (s_hburst == 3'd6 || s_hburst == 3'd7) ? 4'd15 : 4'd0;
  assign w_beats_nx = w_nonseq ? w_load :
                      (w_seq && r_beats_left != 4'd0) ? r_beats_left - 4'd1 : r_beats_left;
  // A NONSEQ opening a multi-beat fixed burst keeps the current owner, cancelling the boundary
  assign w_bound  = s_hready && ((r_beats_left == 4'd0 && !(w_nonseq && w_load != 4'd0)) ||
                                 (w_seq && r_beats_left == 4'd1));
  assign w_any    = |m_busreq;
  assign w_others = |(m_busreq & ~r_grant);
  assign w_release = (r_state == LOCKED) ? !m_hlock[r_owner] :
                     (!m_busreq[r_owner] || (w_exhaust && w_others));
`ifdef AHB_ARB_WEIGHT_EN
  logic [WEIGHT_W-1:0] r_quota, w_quota_nx, w_weight, w_limit;
  assign w_weight   = m_weight[int'(r_owner)*WEIGHT_W +: WEIGHT_W];
  assign w_limit    = (w_weight == '0) ? WEIGHT_W'(1) : w_weight;
  assign w_quota_nx = (w_acc && r_quota != '1) ? r_quota + 1'b1 : r_quota;
  assign w_exhaust  = w_quota_nx >= w_limit;
  always_ff @(posedge hclk) begin
    if (hreset) r_quota <= '0;
    else if (s_hready) r_quota <= w_clr_quota ? '0 : w_quota_nx;
  end
`else
  logic w_unused;
  assign w_unused  = ^{m_weight, w_clr_quota, w_acc};
  assign w_exhaust = 1'b1;
`endif
  // Round-robin search from owner+1; the owner itself is the last candidate
  always_comb begin
    w_sel = r_owner;
    for (int i = N_MASTERS; i >= 1; i--)
      if (m_busreq[(int'(r_owner) + i) % N_MASTERS]) w_sel = IW'((int'(r_owner) + i) % N_MASTERS);
  end
  always_comb begin
    w_state_nx  = r_state;
    w_owner_nx  = r_owner;
    w_clr_quota = 1'b0;
    if (r_state == PARK) begin
      if (w_any) begin
        w_state_nx  = GRANTED;
        w_owner_nx  = w_sel;
        w_clr_quota = 1'b1;
      end
    end else if (r_state == HANDOVER) begin
      w_state_nx  = GRANTED;
      w_clr_quota = 1'b1;
    end else if (w_bound && r_state == GRANTED && m_hlock[r_owner]) begin
      w_state_nx = LOCKED;
    end else if (w_bound && w_release) begin
      w_state_nx  = !w_any ? PARK : (w_sel == r_owner) ? GRANTED : HANDOVER;
      w_owner_nx  = w_any ? w_sel : DEF_IDX;
      w_clr_quota = 1'b1;
    end
  end
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state      <= PARK;
      r_owner      <= DEF_IDX;
      r_grant      <= N_MASTERS'(1) << DEF_IDX;
      r_hmaster    <= DEF_IDX;
      r_mastlock   <= 1'b0;
      r_beats_left <= 4'd0;
    end else if (s_hready) begin
      r_state      <= w_state_nx;
      r_owner      <= w_owner_nx;
      r_grant      <= N_MASTERS'(1) << w_owner_nx;
      r_hmaster    <= r_owner;
      r_mastlock   <= m_hlock[r_owner] && (r_state == GRANTED || r_state == LOCKED);
      r_beats_left <= w_beats_nx;
    end
  end
  assign hgrant      = r_grant;
  assign s_hmaster   = r_hmaster;
  assign s_hmastlock = r_mastlock;
endmodule

// File: tb/tb_ahb_grant_scheduler.sv
// tb_ahb_grant_scheduler: scoreboard bench for ahb_grant_scheduler (N_MASTERS=4, DEF_MASTER=0).
module tb_ahb_grant_scheduler;
  localparam logic [1:0] IDL = 2'd0, NS = 2'd2, SQ = 2'd3;
  localparam logic [2:0] SGL = 3'd0, I4 = 3'd3, I8 = 3'd5, I16 = 3'd7;
  logic hclk = 1'b0, hreset;
  logic [3:0] m_busreq, m_hlock, hgrant;
  logic [15:0] m_weight;
  logic s_hready, s_hmastlock;
  logic [1:0] s_htrans, s_hmaster;
  logic [2:0] s_hburst;
  int n_chk = 0, n_pass = 0;
  typedef struct {logic [3:0] g; logic [1:0] m; logic l;} exp_t;
  exp_t sb[$];
  int g1[6] = '{2, 4, 4, 2, 2, 4};
  int h1[6] = '{0, 1, 2, 2, 1, 1};
`ifdef AHB_ARB_WEIGHT_EN
  int g4[10] = '{2, 2, 2, 4, 4, 2, 2, 2, 2, 4};
  int h4[10] = '{0, 1, 1, 1, 2, 2, 1, 1, 1, 1};
`else
  int g4[10] = '{2, 4, 4, 2, 2, 4, 4, 2, 2, 4};
  int h4[10] = '{0, 1, 2, 2, 1, 1, 2, 2, 1, 1};
`endif
  ahb_grant_scheduler dut (
    .hclk(hclk), .hreset(hreset), .m_busreq(m_busreq), .m_hlock(m_hlock), .m_weight(m_weight),
    .s_hready(s_hready), .s_htrans(s_htrans), .s_hburst(s_hburst),
    .hgrant(hgrant), .s_hmaster(s_hmaster), .s_hmastlock(s_hmastlock)
  );
  always #5 hclk = ~hclk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask
  task automatic cyc(input string tag, input logic [3:0] req, input logic [3:0] lock, input logic [1:0] tr,
                     input logic [2:0] hb, input logic rdy, input logic [3:0] eg, input logic [1:0] em, input logic el);
    exp_t e;
    m_busreq = req; m_hlock = lock; s_htrans = tr; s_hburst = hb; s_hready = rdy;
    sb.push_back('{g: eg, m: em, l: el});
    @(posedge hclk); #1;
    e = sb.pop_front();
    check({tag, ".hgrant"}, 32'(hgrant), 32'(e.g));
    check({tag, ".hmaster"}, 32'(s_hmaster), 32'(e.m));
    check({tag, ".hmastlock"}, 32'(s_hmastlock), 32'(e.l));
  endtask
  task automatic do_reset(input logic [15:0] w);
    hreset = 1'b1; m_weight = w; m_busreq = '0; m_hlock = '0;
    s_htrans = IDL; s_hburst = SGL; s_hready = 1'b1;
    @(posedge hclk); #1;
    hreset = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    do_reset(16'h1111);
    check("rst.hgrant", 32'(hgrant), 32'h1);
    check("rst.hmaster", 32'(s_hmaster), 32'h0);
    check("rst.hmastlock", 32'(s_hmastlock), 32'h0);
    check("rst.beats", 32'(dut.r_beats_left), 32'h0);
    for (int i = 0; i < 10; i++) cyc($sformatf("park%0d", i), 4'b0000, 4'b0000, IDL, SGL, 1'b1, 4'b0001, 2'd0, 1'b0);
    for (int i = 0; i < 6; i++) cyc($sformatf("rr%0d", i), 4'b0110, 4'b0000, NS, SGL, 1'b1, 4'(g1[i]), 2'(h1[i]), 1'b0);
    // INCR8 by master 1 while master 3 waits; master 1 drops its request mid-burst
    do_reset(16'h1111);
    cyc("b8.g0", 4'b0010, 4'b0000, IDL, SGL, 1'b1, 4'b0010, 2'd0, 1'b0);
    cyc("b8.g1", 4'b0010, 4'b0000, IDL, SGL, 1'b1, 4'b0010, 2'd1, 1'b0);
    cyc("b8.ns", 4'b1010, 4'b0000, NS, I8, 1'b1, 4'b0010, 2'd1, 1'b0);
    for (int i = 1; i <= 3; i++) cyc($sformatf("b8.sq%0d", i), 4'b1010, 4'b0000, SQ, I8, 1'b1, 4'b0010, 2'd1, 1'b0);
    cyc("b8.stall", 4'b1010, 4'b0000, SQ, I8, 1'b0, 4'b0010, 2'd1, 1'b0);
    for (int i = 4; i <= 6; i++) cyc($sformatf("b8.sq%0d", i), 4'b1000, 4'b0000, SQ, I8, 1'b1, 4'b0010, 2'd1, 1'b0);
    cyc("b8.sq7", 4'b1000, 4'b0000, SQ, I8, 1'b1, 4'b1000, 2'd1, 1'b0);
    cyc("b8.hand", 4'b1000, 4'b0000, IDL, SGL, 1'b1, 4'b1000, 2'd3, 1'b0);
    // Locked master 2 over two INCR4 bursts while master 0 requests
    do_reset(16'h1111);
    cyc("lk.g0", 4'b0100, 4'b0100, IDL, SGL, 1'b1, 4'b0100, 2'd0, 1'b0);
    cyc("lk.g1", 4'b0100, 4'b0100, IDL, SGL, 1'b1, 4'b0100, 2'd2, 1'b1);
    for (int b = 0; b < 2; b++) begin
      cyc($sformatf("lk.b%0d.ns", b), 4'b0101, 4'b0100, NS, I4, 1'b1, 4'b0100, 2'd2, 1'b1);
      for (int i = 1; i <= 3; i++) cyc($sformatf("lk.b%0d.sq%0d", b, i), 4'b0101, 4'b0100, SQ, I4, 1'b1, 4'b0100, 2'd2, 1'b1);
    end
    cyc("lk.rel", 4'b0101, 4'b0000, IDL, SGL, 1'b1, 4'b0001, 2'd2, 1'b0);
    cyc("lk.hand", 4'b0101, 4'b0000, IDL, SGL, 1'b1, 4'b0001, 2'd0, 1'b0);
    // Weighted scheduling: weight[1]=3, weight[2]=1 (pure round-robin when weights are disabled)
    do_reset(16'h1131);
    for (int i = 0; i < 10; i++) cyc($sformatf("wt%0d", i), 4'b0110, 4'b0000, NS, SGL, 1'b1, 4'(g4[i]), 2'(h4[i]), 1'b0);
    // Reset mid-INCR16 during a ready stall while locked
    do_reset(16'h1111);
    cyc("rs.g0", 4'b0010, 4'b0010, IDL, SGL, 1'b1, 4'b0010, 2'd0, 1'b0);
    cyc("rs.g1", 4'b0010, 4'b0010, IDL, SGL, 1'b1, 4'b0010, 2'd1, 1'b1);
    cyc("rs.ns", 4'b0010, 4'b0010, NS, I16, 1'b1, 4'b0010, 2'd1, 1'b1);
    check("rs.beats.ns", 32'(dut.r_beats_left), 32'd15);
    for (int i = 1; i <= 3; i++) cyc($sformatf("rs.sq%0d", i), 4'b0010, 4'b0010, SQ, I16, 1'b1, 4'b0010, 2'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc($sformatf("rs.stall%0d", i), 4'b0010, 4'b0010, SQ, I16, 1'b0, 4'b0010, 2'd1, 1'b1);
      check($sformatf("rs.beats.stall%0d", i), 32'(dut.r_beats_left), 32'd12);
    end
    hreset = 1'b1;
    cyc("rs.reset", 4'b0010, 4'b0010, SQ, I16, 1'b0, 4'b0001, 2'd0, 1'b0);
    check("rs.beats.reset", 32'(dut.r_beats_left), 32'd0);
    hreset = 1'b0;
    cyc("rs.park", 4'b0000, 4'b0000, IDL, SGL, 1'b1, 4'b0001, 2'd0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
